// File: rtl/ifmap_window_scheduler_pkg.sv
// Shared types and default parameters for the IFMap window scheduler.
package ifmap_window_scheduler_pkg;

  localparam int unsigned DefPointerSize = 8;
  localparam int unsigned DefStrideSize  = 3;
  localparam int unsigned DefIfmapSize   = 16;
  localparam int unsigned StallCntWidth  = 16;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSlide,
    StRowEnd,
    StDone
  } state_e;

endpackage

// File: rtl/ifmap_window_counter.sv
// Window start (ws) and in-window offset (k) counters with window-complete and row-end detection.
module ifmap_window_counter
  import ifmap_window_scheduler_pkg::*;
#(
  parameter int unsigned POINTER_SIZE = DefPointerSize,
  parameter int unsigned STRIDE_SIZE  = DefStrideSize
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    row_clear,
  input  logic                    transfer,
  input  logic [POINTER_SIZE-1:0] row_len,
  input  logic [POINTER_SIZE-1:0] filter_len,
  input  logic [STRIDE_SIZE-1:0]  stride,
  output logic [POINTER_SIZE-1:0] ws,
  output logic [POINTER_SIZE-1:0] k,
  output logic                    win_done,
  output logic                    row_last
);

  logic [POINTER_SIZE-1:0] ws_q, k_q, last_k;
  logic [POINTER_SIZE:0]   step, reach;

  // A zero stride would never advance, so it behaves as a stride of one.
  assign step   = (stride == '0) ? (POINTER_SIZE+1)'(1) : (POINTER_SIZE+1)'(stride);
  assign last_k = filter_len - 1'b1;
  assign reach  = {1'b0, ws_q} + step + {1'b0, filter_len};

  assign win_done = transfer && (k_q == last_k);
  assign row_last = win_done && (reach > {1'b0, row_len});
  assign ws       = ws_q;
  assign k        = k_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ws_q <= '0;
      k_q  <= '0;
    end else if (clear || row_clear) begin
      ws_q <= '0;
      k_q  <= '0;
    end else if (win_done) begin
      k_q <= '0;
      if (!row_last) begin
        ws_q <= ws_q + step[POINTER_SIZE-1:0];
      end
    end else if (transfer) begin
      k_q <= k_q + 1'b1;
    end
  end

endmodule

// File: rtl/ifmap_window_scheduler.sv
// Sliding-window read scheduler for the IFMap buffer.
// Optional IFMAP_SCHED_STALL_CNT_EN adds a saturating stall_cycles counter output.
module ifmap_window_scheduler
  import ifmap_window_scheduler_pkg::*;
#(
  parameter int unsigned POINTER_SIZE = DefPointerSize,
  parameter int unsigned STRIDE_SIZE  = DefStrideSize,
  parameter int unsigned IFMAP_SIZE   = DefIfmapSize
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [POINTER_SIZE-1:0]  row_len,
  input  logic [POINTER_SIZE-1:0]  filter_len,
  input  logic [STRIDE_SIZE-1:0]   stride,
  input  logic [POINTER_SIZE-1:0]  num_rows,
  input  logic                     av_data,
  input  logic                     out_ready,
  output logic [POINTER_SIZE-1:0]  read_pointer,
  output logic                     out_valid,
  output logic                     co_filter,
  output logic                     next_row,
  output logic                     end_row,
  output logic                     ld_start_row,
  output logic                     busy,
`ifdef IFMAP_SCHED_STALL_CNT_EN
  output logic                     done,
  output logic [StallCntWidth-1:0] stall_cycles
`else
  output logic                     done
`endif
);

  state_e                  state_q, state_d;
  logic [POINTER_SIZE-1:0] row_len_q, filter_len_q, num_rows_q, base_q, r_q;
  logic [STRIDE_SIZE-1:0]  stride_q;
  logic [POINTER_SIZE-1:0] ws, k;
  logic                    job_start, job_empty, in_slide, transfer, win_done, row_last;

  assign job_start    = (state_q == StIdle) && start;
  assign job_empty    = (filter_len == '0) || (filter_len > row_len) || (num_rows == '0);
  assign in_slide     = (state_q == StSlide);
  assign out_valid    = in_slide && av_data;
  assign transfer     = out_valid && out_ready;
  assign read_pointer = in_slide ? (base_q + ws + k) : '0;
  assign co_filter    = win_done;
  assign end_row      = row_last;
  assign busy         = (state_q != StIdle);

  ifmap_window_counter #(
    .POINTER_SIZE (POINTER_SIZE),
    .STRIDE_SIZE  (STRIDE_SIZE)
  ) u_window_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (job_start),
    .row_clear  (state_q == StRowEnd),
    .transfer   (transfer),
    .row_len    (row_len_q),
    .filter_len (filter_len_q),
    .stride     (stride_q),
    .ws         (ws),
    .k          (k),
    .win_done   (win_done),
    .row_last   (row_last)
  );

  always_comb begin
    state_d      = state_q;
    ld_start_row = 1'b0;
    next_row     = 1'b0;
    done         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = job_empty ? StDone : StLoad;
        end
      end
      StLoad: begin
        ld_start_row = 1'b1;
        state_d      = StSlide;
      end
      StSlide: begin
        if (row_last) begin
          state_d = StRowEnd;
        end
      end
      StRowEnd: begin
        next_row = 1'b1;
        state_d  = (({1'b0, r_q} + 1'b1) == {1'b0, num_rows_q}) ? StDone : StLoad;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // base persists across jobs so consecutive jobs walk through the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      row_len_q    <= '0;
      filter_len_q <= '0;
      stride_q     <= '0;
      num_rows_q   <= '0;
      base_q       <= '0;
      r_q          <= '0;
    end else begin
      state_q <= state_d;
      if (job_start) begin
        row_len_q    <= row_len;
        filter_len_q <= filter_len;
        stride_q     <= stride;
        num_rows_q   <= num_rows;
        r_q          <= '0;
      end else if (state_q == StRowEnd) begin
        base_q <= base_q + row_len_q;
        r_q    <= r_q + 1'b1;
      end
    end
  end

`ifdef IFMAP_SCHED_STALL_CNT_EN
  logic [StallCntWidth-1:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (job_start) begin
      stall_q <= '0;
    end else if (in_slide && !av_data && (stall_q != {StallCntWidth{1'b1}})) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cycles = stall_q;
`endif

  depth_fits_a: assert property (@(posedge clk) disable iff (!rst_n)
    IFMAP_SIZE <= (2 ** POINTER_SIZE));

endmodule

// File: doc/ifmap_window_scheduler.md
IFMAP_WINDOW_SCHEDULER -- requirements
Module: ifmap_window_scheduler

Interface
REQ-001 SHALL have parameter POINTER_SIZE, default 8, meaning IFMap buffer pointer width.
REQ-002 SHALL have parameter STRIDE_SIZE, default 3, meaning stride field width.
REQ-003 SHALL have parameter IFMAP_SIZE, default 16, meaning IFMap buffer depth in words.
REQ-004 SHALL have ports: clk in 1 clock; rst_n in 1 reset, asynchronous, active-low (one clock, no other reset).
REQ-005 SHALL have ports: start in 1 begin job; row_len in POINTER_SIZE words per row; filter_len in POINTER_SIZE window width; stride in STRIDE_SIZE window advance; num_rows in POINTER_SIZE rows in job.
REQ-006 SHALL have ports: av_data in 1 buffer holds unread data; out_ready in 1 downstream accepts read.
REQ-007 SHALL have ports: read_pointer out POINTER_SIZE buffer read address; out_valid out 1 read_pointer valid; co_filter out 1 window complete; next_row out 1 row retire; end_row out 1 last window of row; ld_start_row out 1 load row base; busy out 1; done out 1.

Function
REQ-008 SHALL implement FSM IDLE, LOAD, SLIDE, ROW_END, DONE.
REQ-009 IDLE: start=1 latches row_len, filter_len, stride, num_rows, clears window start ws, offset k and row count r; next state LOAD.
REQ-010 LOAD: ld_start_row=1 for exactly one cycle; next state SLIDE.
REQ-011 SLIDE: out_valid=av_data; read_pointer=(base+ws+k) mod 2^POINTER_SIZE; a transfer is out_valid&&out_ready.
REQ-012 On transfer with k<filter_len-1: k increments; otherwise k clears, co_filter=1 that cycle.
REQ-013 On window completion: if ws+stride+filter_len<=row_len (computed in POINTER_SIZE+1 bits), ws+=stride, stay SLIDE; else end_row=1 same cycle, next state ROW_END.
REQ-014 ROW_END: next_row=1 one cycle; base+=row_len (wraps); r increments; if r+1==num_rows next state DONE, else ws=0, next state LOAD.
REQ-015 DONE: done=1 one cycle, then IDLE; busy=1 in every state except IDLE.
REQ-016 No transfer while av_data=0 or out_ready=0; pointer and k hold stable (no change while out_valid&&!out_ready).
REQ-017 start ignored outside IDLE.
REQ-018 filter_len=0 or filter_len>row_len or num_rows=0: job goes LOAD-free straight to DONE (done pulse, no reads).
REQ-019 stride=0 treated as stride 1.
REQ-020 Latency: first out_valid no earlier than 2 cycles after start (IDLE->LOAD->SLIDE).

Reset
REQ-021 rst_n low asynchronously forces IDLE; all outputs 0; ws, k, r, base cleared.
REQ-022 Reset mid-job abandons job; no co_filter/next_row/done pulse emitted after deassertion.

Configuration
REQ-023 Macro IFMAP_SCHED_STALL_CNT_EN defined: adds output stall_cycles (16 bits) counting SLIDE cycles with av_data=0, saturating at 16'hFFFF, cleared on start and reset.
REQ-024 Macro undefined: port stall_cycles and counter absent; all other behaviour identical.

Structure
REQ-025 Shared package SHALL hold the FSM state enum and default parameter constants.
REQ-026 One sub-module, ifmap_window_counter (ws/k counters, window-complete and row-end compare), is natural; FSM stays in top.

Verification
REQ-027 row_len=8, filter_len=3, stride=1, num_rows=1, av_data/out_ready=1 -> pointers 0,1,2,1,2,3,...,5,6,7; six co_filter pulses; end_row with last; done.
REQ-028 row_len=8, filter_len=3, stride=2 -> windows at 0,2,4; end_row on window 4 (4+2+3>8); three co_filter.
REQ-029 out_ready low 3 cycles mid-window -> read_pointer and out_valid held, no k change, sequence resumes unchanged.
REQ-030 num_rows=2, row_len=8, base wraps IFMAP pointer from 252 -> second row pointers start at 4 (mod 256), ld_start_row before each row, one done.
REQ-031 filter_len=0 with start -> done pulse, zero out_valid cycles; rst_n low during SLIDE -> all outputs 0 immediately, IDLE.
REQ-032 With IFMAP_SCHED_STALL_CNT_EN: av_data low 5 SLIDE cycles -> stall_cycles=5.
